// File: rtl/gpu_raster_core.sv
// APB-programmed rectangle rasterizer. Commands queue in a small FIFO and are
// drawn one pixel per clock into the back half of a double-buffered SRAM.
module gpu_raster_core #(
   parameter int CHANNEL_BITS  = 8,
   parameter int WIDTH_BITS    = 10,
   parameter int HEIGHT_BITS   = 9,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [31:0]                       pAddr_i,
   input  logic [31:0]                       pDataWrite_i,
   input  logic                              pSel_i,
   input  logic                              pEnable_i,
   input  logic                              pWrite_i,
   output logic                              CE0_o,
   output logic                              CE1_o,
   output logic                              R_W_o,
   output logic                              OE_o,
   output logic                              LB_o,
   output logic                              UB_o,
   output logic                              SEM_o,
   output logic                              ZZ_o,
   output logic [3*CHANNEL_BITS-1:0]         rgbdataout_o,
   output logic [WIDTH_BITS+HEIGHT_BITS:0]   adddataout_o,
   output logic                              buffer_select_o,
   output logic                              full_change_irq_o
);
   // state | meaning
   // IDLE  | waiting for a queued command; pops when the FIFO is non-empty
   // SETUP | clip the popped rectangle, or flip the front buffer for SWAP
   // DRAW  | one SRAM write per cycle in raster order
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

   localparam int CW      = 3*CHANNEL_BITS;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 2 + CW + 64;
   localparam logic [1:0]  OP_CLEAR = 2'd1;
   localparam logic [1:0]  OP_SWAP  = 2'd3;
   localparam logic [15:0] X_MAX    = 16'(SCREEN_WIDTH - 1);
   localparam logic [15:0] Y_MAX    = 16'(SCREEN_HEIGHT - 1);

   state_t state, state_next;

   logic [CW-1:0]      color_r;
   logic [31:0]        p0_r, p1_r;
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full, full_r, apb_wr, push, pop;

   logic [1:0]             cmd_op;
   logic [CW-1:0]          cmd_color;
   logic [31:0]            cmd_p0, cmd_p1;
   logic [15:0]            x0c, y0c, x1c, y1c;
   logic                   empty_rect, last_pix;
   logic [WIDTH_BITS-1:0]  cx, xs, xe;
   logic [HEIGHT_BITS-1:0] cy, ye;
   logic                   unused_bits;

   assign unused_bits = ^{pAddr_i[31:4], pDataWrite_i[31:CW]};

   assign apb_wr = pSel_i & pEnable_i & pWrite_i;
   assign full   = (count == CNT_W'(FIFO_DEPTH));
   assign push   = apb_wr && (pAddr_i[3:0] == 4'h0) && (pDataWrite_i[1:0] != 2'd0) && !full;
   assign pop    = (state == S_IDLE) && (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         color_r <= '0;
         p0_r    <= '0;
         p1_r    <= '0;
      end else if (apb_wr) begin
         case (pAddr_i[3:0])
            4'h4:    color_r <= pDataWrite_i[CW-1:0];
            4'h8:    p0_r    <= pDataWrite_i;
            4'hC:    p1_r    <= pDataWrite_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {pDataWrite_i[1:0], color_r, p0_r, p1_r};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         full_r            <= 1'b0;
         full_change_irq_o <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         full_r            <= full;
         full_change_irq_o <= full ^ full_r;
      end
   end

   // Lower bounds need no clamp: coordinates are unsigned.
   always_comb begin
      x0c = cmd_p0[15:0];
      y0c = cmd_p0[31:16];
      x1c = (cmd_p1[15:0]  > X_MAX) ? X_MAX : cmd_p1[15:0];
      y1c = (cmd_p1[31:16] > Y_MAX) ? Y_MAX : cmd_p1[31:16];
      if (cmd_op == OP_CLEAR) begin
         x0c = '0;
         y0c = '0;
         x1c = X_MAX;
         y1c = Y_MAX;
      end
      empty_rect = (x0c > x1c) || (y0c > y1c);
   end

   assign last_pix = (cx == xe) && (cy == ye);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      CE0_o        = 1'b1;
      CE1_o        = 1'b0;
      R_W_o        = 1'b1;
      OE_o         = 1'b1;
      LB_o         = 1'b1;
      UB_o         = 1'b1;
      SEM_o        = 1'b1;
      ZZ_o         = 1'b0;
      rgbdataout_o = '0;
      adddataout_o = '0;
      case (state)
         S_IDLE:  if (count != '0) state_next = S_SETUP;
         S_SETUP: state_next = ((cmd_op == OP_SWAP) || empty_rect) ? S_IDLE : S_DRAW;
         S_DRAW: begin
            CE0_o        = 1'b0;
            CE1_o        = 1'b1;
            R_W_o        = 1'b0;
            LB_o         = 1'b0;
            UB_o         = 1'b0;
            rgbdataout_o = cmd_color;
            adddataout_o = {~buffer_select_o, cy, cx};
            if (last_pix) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_op          <= '0;
         cmd_color       <= '0;
         cmd_p0          <= '0;
         cmd_p1          <= '0;
         cx              <= '0;
         cy              <= '0;
         xs              <= '0;
         xe              <= '0;
         ye              <= '0;
         buffer_select_o <= 1'b0;
      end else begin
         if (pop) {cmd_op, cmd_color, cmd_p0, cmd_p1} <= fifo_mem[rd_ptr];
         if (state == S_SETUP) begin
            if (cmd_op == OP_SWAP) begin
               buffer_select_o <= ~buffer_select_o;
            end else begin
               cx <= x0c[WIDTH_BITS-1:0];
               xs <= x0c[WIDTH_BITS-1:0];
               xe <= x1c[WIDTH_BITS-1:0];
               cy <= y0c[HEIGHT_BITS-1:0];
               ye <= y1c[HEIGHT_BITS-1:0];
            end
         end else if (state == S_DRAW) begin
            if (cx == xe) begin
               cx <= xs;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gpu_raster_core.sv
// Bench for gpu_raster_core: directed sequence plus random rectangles, with
// expected pixel writes produced by a rectangle/clip reference model.
module tb_gpu_raster_core;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam logic [7:0] PINS_IDLE = 8'b10111110;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] paddr = '0, pdata = '0;
   logic        psel = 1'b0, pen = 1'b0, pwrite = 1'b0;
   logic        ce0, ce1, r_w, oe, lb, ub, sem, zz, bsel, irq;
   logic [23:0] rgb;
   logic [19:0] addr;

   gpu_raster_core dut (
      .clk(clk), .rst(rst), .pAddr_i(paddr), .pDataWrite_i(pdata),
      .pSel_i(psel), .pEnable_i(pen), .pWrite_i(pwrite),
      .CE0_o(ce0), .CE1_o(ce1), .R_W_o(r_w), .OE_o(oe), .LB_o(lb), .UB_o(ub),
      .SEM_o(sem), .ZZ_o(zz), .rgbdataout_o(rgb), .adddataout_o(addr),
      .buffer_select_o(bsel), .full_change_irq_o(irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef logic [43:0] pix_t;
   pix_t exp_q[$];
   int   wcyc[$];
   int   irq_cyc[$];
   int   wcount = 0;
   int   n_pass = 0, n_fail = 0, n_total = 0;
   logic bufsel_m = 1'b0;
   logic [23:0] s_color = '0;
   int   s_x0 = 0, s_y0 = 0, s_x1 = 0, s_y1 = 0;
   int   last_commit = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: SWAP flips the back buffer; rectangles clip their far corner
   // to the screen and emit pixels x-fastest into the current back buffer.
   task automatic model_cmd(input int op);
      int xa, ya, xb, yb;
      if (op == 3) begin
         bufsel_m = ~bufsel_m;
      end else if (op == 1 || op == 2) begin
         if (op == 1) begin
            xa = 0; ya = 0; xb = SW - 1; yb = SH - 1;
         end else begin
            xa = s_x0; ya = s_y0;
            xb = (s_x1 > SW - 1) ? SW - 1 : s_x1;
            yb = (s_y1 > SH - 1) ? SH - 1 : s_y1;
         end
         for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
               exp_q.push_back({~bufsel_m, 9'(y), 10'(x), s_color});
      end
   endtask

   task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
      paddr = {28'h0, a}; pdata = d; psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
      @(posedge clk); #1 pen = 1'b1;
      @(posedge clk); #1 last_commit = cyc;
      psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
   endtask

   task automatic set_rect(input logic [23:0] c, input int x0, input int y0, input int x1, input int y1);
      s_color = c; s_x0 = x0; s_y0 = y0; s_x1 = x1; s_y1 = y1;
      apb_wr(4'h4, {8'h0, c});
      apb_wr(4'h8, {16'(y0), 16'(x0)});
      apb_wr(4'hC, {16'(y1), 16'(x1)});
   endtask

   task automatic send_cmd(input int op);
      apb_wr(4'h0, 32'(op));
      model_cmd(op);
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1 check("drain", 64'(exp_q.size()), 0);
   endtask

   always @(negedge clk) begin : monitor
      pix_t e;
      if (rst === 1'b0) begin
         if (irq === 1'b1) irq_cyc.push_back(cyc);
         if (r_w === 1'b0) begin
            wcount++;
            wcyc.push_back(cyc);
            check("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("pix_addr", 64'(addr), 64'(e[43:24]));
               check("pix_rgb", 64'(rgb), 64'(e[23:0]));
            end
            check("write_pins", {ce0, ce1, oe, lb, ub, sem, zz}, 7'b0110010);
         end else begin
            check("idle_pins", {ce0, ce1, r_w, oe, lb, ub, sem, zz}, PINS_IDLE);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, lat, x0, y0, x1, y1, op;
      int bc[5];
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_pins", {ce0, ce1, r_w, oe, lb, ub, sem, zz}, PINS_IDLE);
      check("rst_bsel", bsel, 0);
      check("rst_rgb_addr", {rgb, addr}, 0);
      check("rst_no_irq", 64'(irq_cyc.size()), 0);
      check("rst_no_writes", 64'(wcount), 0);

      // 2x2 rectangle: latency and raster order into buffer 1
      set_rect(24'hFF0000, 2, 3, 3, 4);
      wcyc.delete();
      send_cmd(2);
      lat = last_commit;
      wait_drain(50);
      check("rect_writes", 64'(wcyc.size()), 4);
      lat = (wcyc.size() > 0) ? wcyc[0] - lat : -1;
      check("first_latency", 64'(lat), 2);

      // SWAP queued behind a rectangle, then a rectangle into buffer 0
      set_rect(24'h00FF00, 10, 20, 13, 22);
      send_cmd(2);
      send_cmd(3);
      wait_drain(100);
      check("bsel_after_swap", bsel, 1);
      set_rect(24'h0000FF, 5, 5, 6, 5);
      send_cmd(2);
      wait_drain(50);

      // Fully clipped rectangle, then a normal one to show the engine is idle
      w0 = wcount;
      set_rect(24'h123456, 700, 10, 800, 12);
      send_cmd(2);
      repeat (10) @(posedge clk);
      #1 check("clip_writes", 64'(wcount - w0), 0);
      set_rect(24'h654321, 637, 479, 700, 600);
      wcyc.delete();
      send_cmd(2);
      lat = last_commit;
      wait_drain(50);
      lat = (wcyc.size() > 0) ? wcyc[0] - lat : -1;
      check("after_clip_latency", 64'(lat), 2);
      check("corner_writes", 64'(wcyc.size()), 3);

      // Random rectangles, NOPs and swaps
      for (int i = 0; i < 10; i++) begin
         x0 = $urandom_range(0, 700);
         y0 = $urandom_range(0, 485);
         x1 = x0 + $urandom_range(0, 6) - 1;
         y1 = y0 + $urandom_range(0, 4) - 1;
         if (x1 < 0) x1 = 0;
         if (y1 < 0) y1 = 0;
         op = $urandom_range(0, 3);
         if (op == 1) op = 2;
         set_rect(24'($urandom), x0, y0, x1, y1);
         send_cmd(op);
         wait_drain(100);
      end

      // FIFO fill while busy: four queued, fifth dropped, irq on fill and on first pop
      wcyc.delete();
      irq_cyc.delete();
      w0 = wcount;
      set_rect(24'hA5A5A5, 0, 0, 49, 0);
      send_cmd(2);
      set_rect(24'h5A5A5A, 100, 200, 109, 209);
      paddr = '0; pdata = 32'd2; psel = 1'b1; pen = 1'b1; pwrite = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 bc[k] = cyc;
      end
      psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
      for (int k = 0; k < 4; k++) model_cmd(2);
      wait_drain(1000);
      check("burst_writes", 64'(wcount - w0), 450);
      check("burst_irq_count", 64'(irq_cyc.size()), 2);
      lat = (irq_cyc.size() > 0) ? irq_cyc[0] - bc[3] : -1;
      check("irq_on_full", 64'(lat), 1);
      lat = (irq_cyc.size() > 1 && wcyc.size() > 49) ? irq_cyc[1] - wcyc[49] : -1;
      check("irq_on_first_pop", 64'(lat), 3);

      // CLEAR with two more queued, reset mid-draw
      w0 = wcount;
      send_cmd(1);
      set_rect(24'h0F0F0F, 1, 1, 2, 2);
      send_cmd(2);
      send_cmd(2);
      for (int i = 0; i < 2000 && (wcount - w0) < 700; i++) @(posedge clk);
      #1 check("clear_progress", 64'(wcount - w0 >= 700), 1);
      rst = 1'b1;
      exp_q.delete();
      bufsel_m = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_pins", {ce0, ce1, r_w, oe, lb, ub, sem, zz}, PINS_IDLE);
      check("mid_rst_bsel", bsel, 0);
      check("mid_rst_rgb_addr", {rgb, addr}, 0);
      check("mid_rst_irq", irq, 0);
      w0 = wcount;
      repeat (30) @(posedge clk);
      #1 check("post_rst_writes", 64'(wcount - w0), 0);
      set_rect(24'hABCDEF, 630, 478, 639, 479);
      send_cmd(2);
      wait_drain(100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
